fpu_issue: RTL and testbench
============================

Name: fpu_issue

Overview:
- Core-side initiator for the multi-cycle floating-point unit.
- Accepts one FP operation at a time from the execute stage over a valid/ready handshake.
- Drives the opcode and operands to the FPU and holds them stable for that opcode's fixed latency.
- Captures the FPU result and returns it with its destination tag over a valid/ready response handshake. Raises `stall` while an operation is outstanding.

Parameters:
- LAT_ADDSUB, 2, cycles for add (0000) and sub (0001)
- LAT_MUL, 2, cycles for mul (0010)
- LAT_DIV, 4, cycles for div (0011)
- LAT_SQRT, 4, cycles for sqrt (0110)
- LAT_CVT, 1, cycles for itof (1000), ftoi (1001) and floor (1010)
- Latency 0 (fixed, not a parameter): neg (0100), abs (0101), slt (0111), and opcodes 1011-1111.

Ports:
- clk  in  1  system clock, rising edge
- rstn  in  1  synchronous, active-high reset (1 = reset, despite the name)
- flush  in  1  synchronous abort of any outstanding operation
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_op  in  4  FPU opcode
- req_a  in  32  operand A
- req_b  in  32  operand B
- req_rd  in  5  destination register tag
- fpu_control  out  4  opcode to FPU
- fpu_srcA  out  32  operand A to FPU
- fpu_srcB  out  32  operand B to FPU
- fpu_result  in  32  FPU result
- resp_valid  out  1  result available
- resp_ready  in  1  consumer accepts result
- resp_data  out  32  captured result
- resp_rd  out  5  tag of result
- stall  out  1  high when state is not IDLE

Behaviour:
- States: IDLE, EXEC, RESP. Registers: op, a, b, rd, cnt (3 bits), resp_data.
- Reset (rstn=1 at an edge):
  - State becomes IDLE; all registered outputs become 0, including fpu_control, fpu_srcA, fpu_srcB, resp_valid, resp_data and resp_rd.
  - req_ready is 0 in any cycle where rstn is high.
  - Reset in mid-operation discards the operation; no response is produced.
- req_ready = !rstn && (IDLE || (RESP && resp_ready)). Acceptance = req_valid && req_ready.
- On acceptance:
  - Latch req_op, req_a and req_b into fpu_control, fpu_srcA and fpu_srcB, and latch req_rd.
  - cnt <= LAT(req_op). Next state is EXEC.
- EXEC:
  - If cnt != 0, decrement cnt.
  - If cnt == 0, capture: resp_data <= fpu_result (forced to 0 for opcodes 1011-1111), resp_rd <= rd, resp_valid <= 1. Next state is RESP.
- Latency: resp_valid rises after LAT+1 rising edges following the accepting edge.
- fpu_control, fpu_srcA and fpu_srcB stay constant from the accepting edge until the next acceptance, including while IDLE.
- RESP:
  - resp_valid, resp_data and resp_rd stay stable until resp_ready=1.
  - On resp_ready with no new acceptance: clear resp_valid, go to IDLE.
  - On resp_ready with a simultaneous acceptance: clear resp_valid, latch the new request, go to EXEC. This gives zero-bubble back-to-back issue.
- flush=1 at an edge:
  - Go to IDLE and clear resp_valid; any request presented in that cycle is not accepted (req_ready is still driven, but flush overrides acceptance).
  - Priority: rstn > flush > handshake.
- stall = (state != IDLE). Combinational from state.
- The block does not track cnt wrap: LAT values must be 0..7.

Test Plan:
1. Add: A=0x3F800000, B=0x40000000, op=0000, rd=3, with resp_ready=1 -> resp_valid rises 3 edges after accept; resp_data=0x40400000, resp_rd=3; operand ports stable throughout; stall high for 4 cycles.
2. Back-to-back: neg of 0x40000000, then immediately mul 0x40000000*0x40400000 offered during RESP with resp_ready=1 -> first resp_data=0xC0000000; second accepted in the same cycle; second resp_data=0x40C00000 three edges later.
3. Backpressure: div 0x40C00000/0x40000000 with resp_ready=0 for 5 cycles -> resp_valid held with resp_data=0x40400000 stable; req_ready=0 throughout; handshake completes when resp_ready=1.
4. Flush: flush asserted 2 cycles into sqrt of 0x41800000 -> next cycle IDLE, resp_valid never rises; a following add proceeds normally.
5. Reset mid-op: rstn=1 during EXEC of ftoi -> all outputs 0, req_ready=0 while reset is held, no response; IDLE and req_ready=1 after release.
6. Invalid opcode 1111 with A=0xFFFFFFFF -> resp_valid after 1 edge, resp_data=0x00000000.

Source files
------------

// File: rtl/fpu_issue.sv
// Issue/response sequencer for the multi-cycle FPU: holds operands for the
// opcode's fixed latency, then captures and returns the result with its tag.
//
// state | meaning
// IDLE  | no operation outstanding, ready for a request
// EXEC  | operands driven to FPU, latency counter running
// RESP  | result captured, waiting for the consumer to take it
module fpu_issue #(
    parameter int LAT_ADDSUB = 2,
    parameter int LAT_MUL    = 2,
    parameter int LAT_DIV    = 4,
    parameter int LAT_SQRT   = 4,
    parameter int LAT_CVT    = 1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        flush,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic [4:0]  req_rd,
    output logic [3:0]  fpu_control,
    output logic [31:0] fpu_srcA,
    output logic [31:0] fpu_srcB,
    input  logic [31:0] fpu_result,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic [4:0]  resp_rd,
    output logic        stall
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [4:0] rd;
    logic [2:0] cnt;
    logic       accept;

    function automatic logic [2:0] op_lat(input logic [3:0] op);
        case (op)
            4'h0, 4'h1:       return 3'(LAT_ADDSUB);
            4'h2:             return 3'(LAT_MUL);
            4'h3:             return 3'(LAT_DIV);
            4'h6:             return 3'(LAT_SQRT);
            4'h8, 4'h9, 4'hA: return 3'(LAT_CVT);
            default:          return 3'd0;
        endcase
    endfunction

    // Flush wins over the handshake even though req_ready is still driven.
    assign accept = req_valid && req_ready && !flush;

    always_ff @(posedge clk) begin
        if (rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                if (cnt == 3'd0) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (accept) begin
                    state_nxt = EXEC;
                end else if (resp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (flush) begin
            state_nxt = IDLE;
        end
    end

    always_comb begin
        req_ready = 1'b0;
        stall     = 1'b0;
        if (!rstn) begin
            req_ready = (state == IDLE) || ((state == RESP) && resp_ready);
        end
        stall = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            fpu_control <= 4'd0;
            fpu_srcA    <= 32'd0;
            fpu_srcB    <= 32'd0;
            rd          <= 5'd0;
            cnt         <= 3'd0;
            resp_valid  <= 1'b0;
            resp_data   <= 32'd0;
            resp_rd     <= 5'd0;
        end else if (flush) begin
            resp_valid <= 1'b0;
        end else begin
            if ((state == RESP) && resp_ready) begin
                resp_valid <= 1'b0;
            end
            if (accept) begin
                fpu_control <= req_op;
                fpu_srcA    <= req_a;
                fpu_srcB    <= req_b;
                rd          <= req_rd;
                cnt         <= op_lat(req_op);
            end else if (state == EXEC) begin
                if (cnt != 3'd0) begin
                    cnt <= cnt - 3'd1;
                end else begin
                    // Opcodes 1011-1111 have no FPU function; return zero.
                    resp_data  <= (fpu_control >= 4'hB) ? 32'd0 : fpu_result;
                    resp_rd    <= rd;
                    resp_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fpu_issue.sv
// Directed bench for fpu_issue: a transaction-level model predicts every
// output each cycle, and directed scenarios pin latencies and results.
module tb_fpu_issue;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        flush = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_op = 4'd0;
    logic [31:0] req_a = 32'd0;
    logic [31:0] req_b = 32'd0;
    logic [4:0]  req_rd = 5'd0;
    logic [3:0]  fpu_control;
    logic [31:0] fpu_srcA;
    logic [31:0] fpu_srcB;
    logic [31:0] fpu_result;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_data;
    logic [4:0]  resp_rd;
    logic        stall;

    int nchk = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    fpu_issue dut (
        .clk(clk), .rstn(rstn), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_rd(req_rd),
        .fpu_control(fpu_control), .fpu_srcA(fpu_srcA), .fpu_srcB(fpu_srcB),
        .fpu_result(fpu_result),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_rd(resp_rd), .stall(stall)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int tb_lat(input logic [3:0] op);
        case (op)
            4'h0, 4'h1:       return 2;
            4'h2:             return 2;
            4'h3:             return 4;
            4'h6:             return 4;
            4'h8, 4'h9, 4'hA: return 1;
            default:          return 0;
        endcase
    endfunction

    // Stand-in FPU: known float cases, otherwise distinct integer garbage.
    function automatic logic [31:0] fake_fpu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'h0: return (a == 32'h3F800000 && b == 32'h40000000) ? 32'h40400000 : a + b;
            4'h1: return a - b;
            4'h2: return (a == 32'h40000000 && b == 32'h40400000) ? 32'h40C00000 : a ^ b;
            4'h3: return (a == 32'h40C00000 && b == 32'h40000000) ? 32'h40400000 : a | b;
            4'h4: return a ^ 32'h80000000;
            4'h5: return a & 32'h7FFFFFFF;
            4'h6: return (a == 32'h41800000) ? 32'h40800000 : a >> 1;
            4'h7: return {31'd0, $signed(a) < $signed(b)};
            4'h8, 4'h9, 4'hA: return a + 32'h1000;
            default: return a ^ b ^ 32'h5A5A5A5A;
        endcase
    endfunction

    // Model state: one pending op with a due edge, plus a held response.
    bit          started = 0;
    bit          pend = 0;
    bit          rsp = 0;
    int          cyc = 0;
    int          due = 0;
    int          age = 0;
    int          age_q = 0;
    logic [3:0]  m_op = 4'd0;
    logic [31:0] m_a = 32'd0;
    logic [31:0] m_b = 32'd0;
    logic [4:0]  m_rd = 5'd0;
    logic [31:0] m_data = 32'd0;
    logic [4:0]  m_rrd = 5'd0;

    // Result is garbage until operands have been held for the op's latency.
    assign fpu_result = (age_q >= tb_lat(fpu_control)) ? fake_fpu(fpu_control, fpu_srcA, fpu_srcB)
                                                       : 32'hDEADBEEF;

    function automatic bit m_ready();
        return !rstn && ((!pend && !rsp) || (rsp && resp_ready));
    endfunction

    always @(posedge clk) begin
        bit acc;
        cyc++;
        acc = req_valid && m_ready() && !flush;
        if (age < 100) age++;
        if (rstn) begin
            started = 1;
            pend = 0; rsp = 0;
            m_op = 4'd0; m_a = 32'd0; m_b = 32'd0; m_rd = 5'd0;
            m_data = 32'd0; m_rrd = 5'd0;
        end else if (flush) begin
            pend = 0; rsp = 0;
        end else begin
            if (rsp && resp_ready) rsp = 0;
            if (pend && cyc == due) begin
                rsp = 1; pend = 0;
                m_data = (m_op >= 4'hB) ? 32'd0 : fake_fpu(m_op, m_a, m_b);
                m_rrd = m_rd;
            end
            if (acc) begin
                pend = 1;
                due = cyc + tb_lat(req_op) + 1;
                m_op = req_op; m_a = req_a; m_b = req_b; m_rd = req_rd;
                age = 0;
            end
        end
        age_q <= age;
    end

    always @(negedge clk) begin
        if (started) begin
            check("req_ready", 32'(req_ready), 32'(m_ready()));
            check("stall", 32'(stall), 32'(pend || rsp));
            check("resp_valid", 32'(resp_valid), 32'(rsp));
            check("resp_data", resp_data, m_data);
            check("resp_rd", 32'(resp_rd), 32'(m_rrd));
            check("fpu_control", 32'(fpu_control), 32'(m_op));
            check("fpu_srcA", fpu_srcA, m_a);
            check("fpu_srcB", fpu_srcB, m_b);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        int n = 0;
        bit done = 0;
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_rd = rd;
        while (!done && n < 20) begin
            done = req_ready && !flush;
            tick();
            n++;
        end
        req_valid = 1'b0;
        check("issue_accepted", 32'(done), 32'd1);
    endtask

    task automatic wait_resp(output int k);
        k = 0;
        while (!resp_valid && k < 20) begin
            tick();
            k++;
        end
    endtask

    initial begin
        int k;
        tick(); tick();
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_fpu_control", 32'(fpu_control), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        rstn = 1'b0;
        #1;
        check("post_rst_req_ready", 32'(req_ready), 32'd1);
        resp_ready = 1'b1;

        // add 1.0 + 2.0
        issue(4'h0, 32'h3F800000, 32'h40000000, 5'd3);
        check("add_stall", 32'(stall), 32'd1);
        wait_resp(k);
        check("add_latency", 32'(k), 32'd3);
        check("add_data", resp_data, 32'h40400000);
        check("add_rd", 32'(resp_rd), 32'd3);
        check("add_srcA_held", fpu_srcA, 32'h3F800000);
        tick();
        check("add_done_stall", 32'(stall), 32'd0);

        // neg then back-to-back mul
        issue(4'h4, 32'h40000000, 32'h0, 5'd5);
        wait_resp(k);
        check("neg_latency", 32'(k), 32'd1);
        check("neg_data", resp_data, 32'hC0000000);
        req_valid = 1'b1; req_op = 4'h2; req_a = 32'h40000000; req_b = 32'h40400000; req_rd = 5'd6;
        #1;
        check("b2b_req_ready", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        check("b2b_valid_cleared", 32'(resp_valid), 32'd0);
        check("b2b_control", 32'(fpu_control), 32'h2);
        wait_resp(k);
        check("mul_latency", 32'(k), 32'd3);
        check("mul_data", resp_data, 32'h40C00000);
        check("mul_rd", 32'(resp_rd), 32'd6);
        tick();

        // div under backpressure
        resp_ready = 1'b0;
        issue(4'h3, 32'h40C00000, 32'h40000000, 5'd7);
        wait_resp(k);
        check("div_latency", 32'(k), 32'd5);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 32'(resp_valid), 32'd1);
            check("bp_data", resp_data, 32'h40400000);
            check("bp_req_ready", 32'(req_ready), 32'd0);
            tick();
        end
        resp_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(req_ready), 32'd1);
        tick();
        check("bp_done_valid", 32'(resp_valid), 32'd0);

        // flush during sqrt
        issue(4'h6, 32'h41800000, 32'h0, 5'd8);
        tick(); tick();
        flush = 1'b1;
        req_valid = 1'b1; req_op = 4'h0; req_a = 32'h1; req_b = 32'h2; req_rd = 5'd12;
        tick();
        flush = 1'b0; req_valid = 1'b0;
        check("flush_stall", 32'(stall), 32'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("flush_no_resp", 32'(resp_valid), 32'd0);
        end
        flush = 1'b1; req_valid = 1'b1;
        #1;
        check("flush_idle_ready", 32'(req_ready), 32'd1);
        tick();
        flush = 1'b0; req_valid = 1'b0;
        check("flush_blocks_accept", 32'(stall), 32'd0);
        check("flush_ops_held", fpu_srcA, 32'h41800000);
        issue(4'h0, 32'h3F800000, 32'h40000000, 5'd9);
        wait_resp(k);
        check("post_flush_latency", 32'(k), 32'd3);
        check("post_flush_data", resp_data, 32'h40400000);
        check("post_flush_rd", 32'(resp_rd), 32'd9);
        tick();

        // reset mid ftoi
        issue(4'h9, 32'h40A00000, 32'h0, 5'd10);
        tick();
        rstn = 1'b1; req_valid = 1'b1; req_op = 4'h0;
        #1;
        check("mid_rst_req_ready", 32'(req_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("mid_rst_valid", 32'(resp_valid), 32'd0);
            check("mid_rst_control", 32'(fpu_control), 32'd0);
            check("mid_rst_srcA", fpu_srcA, 32'd0);
            check("mid_rst_data", resp_data, 32'd0);
            check("mid_rst_stall", 32'(stall), 32'd0);
            check("mid_rst_req_ready2", 32'(req_ready), 32'd0);
        end
        rstn = 1'b0; req_valid = 1'b0;
        #1;
        check("rel_req_ready", 32'(req_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rel_no_resp", 32'(resp_valid), 32'd0);
        end

        // invalid opcode
        issue(4'hF, 32'hFFFFFFFF, 32'h0, 5'd11);
        wait_resp(k);
        check("inv_latency", 32'(k), 32'd1);
        check("inv_data", resp_data, 32'h0);
        check("inv_rd", 32'(resp_rd), 32'd11);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
